sync_set_ctrl: RTL and testbench
================================

SYNC_SET_CTRL -- requirements
Module: sync_set_ctrl

Interface
REQ-001 Parameter SYNC_PERIOD_CNT, default 81920, the expected SYS_TIME advance between consecutive SYNC pulses.
REQ-002 Parameter TIMEOUT_CYCLES, default 163840, the maximum number of CLK cycles allowed without a SYNC pulse.
REQ-003 Parameter SETTLE_SYNCS, default 2, the number of in-tolerance SYNC periods required before lock.
REQ-004 Parameter DRIFT_TOL, default 64, the maximum absolute period error in SYS_TIME counts.
REQ-005 CLK  in  1  the only clock, 163.84 MHz.
REQ-006 RST_N  in  1  reset, synchronous and active-low.
REQ-007 REQ_VALID  in  1  request to load a new sync time.
REQ-008 REQ_TIME  in  64  requested ECAT sync time in ns.
REQ-009 REQ_READY  out  1  high when a request can be accepted.
REQ-010 CLEAR_ERR  in  1  single-cycle pulse that clears the sticky error flags.
REQ-011 SYNC  in  1  single-cycle sync pulse from the synchronizer.
REQ-012 SYS_TIME  in  64  synchronizer system time.
REQ-013 ECAT_SYNC_TIME  out  64  latched time presented to the synchronizer.
REQ-014 SET  out  1  single-cycle load strobe to the synchronizer.
REQ-015 LOCKED  out  1  high when the system time is tracking.
REQ-016 TIMEOUT_ERR  out  1  sticky flag for a missing SYNC.
REQ-017 DRIFT_ERR  out  1  sticky flag for a period error beyond tolerance.
REQ-018 PERIOD_ERR  out  32  signed value of the last measured delta minus SYNC_PERIOD_CNT, saturated to ±2^31-1.

Function
REQ-019 The state machine SHALL have the states IDLE, ARM, LOAD, SETTLE, LOCK and ERROR.
REQ-020 REQ_READY SHALL be high in IDLE, LOCK and ERROR, and low otherwise.
REQ-021 On REQ_VALID&REQ_READY, the block SHALL latch REQ_TIME into ECAT_SYNC_TIME, clear LOCKED and the settle count, and enter ARM.
REQ-022 ARM SHALL wait for SYNC; SET SHALL pulse for exactly 1 cycle on the cycle after that SYNC, so SET is aligned ~one full period before the next SYNC. The state then SHALL be LOAD.
REQ-023 A SYNC coincident with request acceptance SHALL NOT count as the arming SYNC.
REQ-024 LOAD SHALL wait for the next SYNC (the load event), capture SYS_TIME into the last-time register, and enter SETTLE.
REQ-025 On each SYNC in SETTLE or LOCK: delta = SYS_TIME - last (64-bit, modulo wrap); err = delta - SYNC_PERIOD_CNT (signed 65-bit); PERIOD_ERR is updated the next cycle; last is updated to SYS_TIME.
REQ-026 In SETTLE, |err| <= DRIFT_TOL SHALL increment the settle count, and |err| > DRIFT_TOL SHALL zero it; when the count reaches SETTLE_SYNCS, the state SHALL be LOCK and LOCKED=1.
REQ-027 In LOCK, |err| > DRIFT_TOL SHALL set DRIFT_ERR, clear LOCKED, zero the settle count, and enter SETTLE.
REQ-028 A watchdog counter SHALL reset on every SYNC and otherwise increment, saturating, in ARM, LOAD, SETTLE and LOCK; it SHALL be held at 0 in IDLE and ERROR.
REQ-029 When the watchdog counter reaches TIMEOUT_CYCLES, the block SHALL set TIMEOUT_ERR, clear LOCKED, and enter ERROR.
REQ-030 ERROR SHALL be left only by an accepted request, which enters ARM.
REQ-031 CLEAR_ERR SHALL clear both sticky flags; an error set in the same cycle SHALL win.
REQ-032 SYNC and a timeout in the same cycle SHALL treat the SYNC as arrived, with no error.
REQ-033 A request accepted in LOCK SHALL restart the sequence at ARM; ECAT_SYNC_TIME SHALL be changed only on acceptance.

Reset
REQ-034 While RST_N=0 at a CLK edge: state=IDLE; ECAT_SYNC_TIME=0, SET=0, LOCKED=0, TIMEOUT_ERR=0, DRIFT_ERR=0, PERIOD_ERR=0; counters and the last-time register=0; REQ_READY=1 from the first cycle after reset.
REQ-035 Reset asserted mid-sequence SHALL abort without a SET pulse in the following cycle.

Configuration
REQ-036 With SYNC_DRIFT_MON_EN defined, REQ-025 to REQ-027 SHALL be implemented.
REQ-037 Without SYNC_DRIFT_MON_EN, SETTLE SHALL count SYNC pulses unconditionally; DRIFT_ERR and PERIOD_ERR SHALL be tied 0; the watchdog and timeout SHALL be unchanged.

Verification
REQ-038 Scenario: request 64'd1_000_000 in IDLE, SYNC every 81920 cycles with SYS_TIME +81920 -> SET 1 cycle after the 1st SYNC; LOCKED rises after the 4th SYNC (load + 2 settle + arm); PERIOD_ERR=0.
REQ-039 Scenario: locked, then one period with SYS_TIME delta 82000 -> PERIOD_ERR=+80, DRIFT_ERR=1, LOCKED=0, state SETTLE; LOCKED returns after 2 further good periods.
REQ-040 Scenario: locked, SYNC stopped -> TIMEOUT_ERR=1 and LOCKED=0 exactly 163840 cycles after the last SYNC; REQ_READY=1.
REQ-041 Scenario: REQ_VALID in the same cycle as SYNC while in LOCK -> that SYNC is ignored; SET follows the next SYNC; ECAT_SYNC_TIME updates in the acceptance cycle.
REQ-042 Scenario: CLEAR_ERR coincident with a new drift violation -> DRIFT_ERR stays 1; CLEAR_ERR alone -> both flags 0.
REQ-043 Scenario: RST_N low for 1 cycle while in LOAD -> all outputs at reset values, no SET, REQ_READY=1 on the next cycle.

Source files
------------

// File: rtl/sync_set_ctrl.sv
// Arms an ECAT sync-time load, strobes SET one cycle after the arming SYNC, then tracks
// the SYNC period until lock. Optional drift monitor: define SYNC_DRIFT_MON_EN.
module sync_set_ctrl #(
  parameter int unsigned SYNC_PERIOD_CNT = 81920,
  parameter int unsigned TIMEOUT_CYCLES  = 163840,
  parameter int unsigned SETTLE_SYNCS    = 2,
  parameter int unsigned DRIFT_TOL       = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  input  logic [63:0] REQ_TIME,
  output logic        REQ_READY,
  input  logic        CLEAR_ERR,
  input  logic        SYNC,
  input  logic [63:0] SYS_TIME,
  output logic [63:0] ECAT_SYNC_TIME,
  output logic        SET,
  output logic        LOCKED,
  output logic        TIMEOUT_ERR,
  output logic        DRIFT_ERR,
  output logic [31:0] PERIOD_ERR
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SC_W = (SETTLE_SYNCS < 1) ? 1 : $clog2(SETTLE_SYNCS + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_DONE = SC_W'(SETTLE_SYNCS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_LOCK   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       ecat_q, ecat_d;
  logic              set_q, set_d;
  logic              locked_q, locked_d;
  logic              tout_q, tout_d;
  logic [SC_W-1:0]   settle_q, settle_d, settle_nx;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              accept, wd_run, timeout, good_p0;

  assign REQ_READY = (state_q == S_IDLE) || (state_q == S_LOCK) || (state_q == S_ERROR);
  assign accept    = REQ_VALID && REQ_READY;
  assign wd_run    = (state_q == S_ARM) || (state_q == S_LOAD) ||
                     (state_q == S_SETTLE) || (state_q == S_LOCK);
  // A SYNC landing on the expiry cycle counts as on time.
  assign timeout   = wd_run && !SYNC && (wdog_q >= WD_LAST);
  assign settle_nx = settle_q + 1'b1;

`ifdef SYNC_DRIFT_MON_EN
  logic [63:0]        last_q, last_d;
  logic        [63:0] delta_p0;
  logic signed [64:0] err_p0;
  logic signed [31:0] perr_p1, perr_d;
  logic               drift_q, drift_d;

  function automatic logic signed [31:0] sat_err(input logic signed [64:0] e);
    if (e > 65'sd2147483647)
      return 32'sh7FFF_FFFF;
    else if (e < -65'sd2147483647)
      return -32'sd2147483647;
    return $signed(e[31:0]);
  endfunction

  function automatic logic in_tol(input logic signed [64:0] e);
    return (e <= $signed(65'(DRIFT_TOL))) && (e >= -$signed(65'(DRIFT_TOL)));
  endfunction

  // Stage p0: period measurement against the previous SYNC timestamp
  assign delta_p0 = SYS_TIME - last_q;
  assign err_p0   = $signed({1'b0, delta_p0}) - $signed(65'(SYNC_PERIOD_CNT));
  assign good_p0  = in_tol(err_p0);

  assign DRIFT_ERR  = drift_q;
  assign PERIOD_ERR = perr_p1;
`else
  logic [63:0] sys_time_unused;
  assign sys_time_unused = SYS_TIME;
  assign good_p0    = 1'b1;
  assign DRIFT_ERR  = 1'b0;
  assign PERIOD_ERR = '0;
`endif

  always_comb begin
    state_d  = state_q;
    ecat_d   = ecat_q;
    set_d    = 1'b0;
    locked_d = locked_q;
    tout_d   = tout_q & ~CLEAR_ERR;
    settle_d = settle_q;
    wdog_d   = wdog_q;
`ifdef SYNC_DRIFT_MON_EN
    drift_d  = drift_q & ~CLEAR_ERR;
    perr_d   = perr_p1;
    last_d   = last_q;
`endif
    if (!wd_run || SYNC)
      wdog_d = '0;
    else if (wdog_q != WD_MAX)
      wdog_d = wdog_q + 1'b1;

    if (accept) begin
      // The SYNC of the acceptance cycle is deliberately ignored.
      ecat_d   = REQ_TIME;
      locked_d = 1'b0;
      settle_d = '0;
      wdog_d   = '0;
      state_d  = S_ARM;
    end else if (timeout) begin
      tout_d   = 1'b1;
      locked_d = 1'b0;
      state_d  = S_ERROR;
    end else if (SYNC) begin
      case (state_q)
        S_ARM: begin
          set_d   = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: begin
`ifdef SYNC_DRIFT_MON_EN
          last_d  = SYS_TIME;
`endif
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
`ifdef SYNC_DRIFT_MON_EN
          perr_d = sat_err(err_p0);
          last_d = SYS_TIME;
`endif
          if (good_p0) begin
            settle_d = settle_nx;
            if (settle_nx >= SC_DONE) begin
              settle_d = SC_DONE;
              locked_d = 1'b1;
              state_d  = S_LOCK;
            end
          end else begin
            settle_d = '0;
          end
        end
`ifdef SYNC_DRIFT_MON_EN
        S_LOCK: begin
          perr_d = sat_err(err_p0);
          last_d = SYS_TIME;
          if (!good_p0) begin
            drift_d  = 1'b1;
            locked_d = 1'b0;
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Stage p1: registered control state and reported period error
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      ecat_q   <= '0;
      set_q    <= 1'b0;
      locked_q <= 1'b0;
      tout_q   <= 1'b0;
      settle_q <= '0;
      wdog_q   <= '0;
`ifdef SYNC_DRIFT_MON_EN
      drift_q  <= 1'b0;
      perr_p1  <= '0;
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ecat_q   <= ecat_d;
      set_q    <= set_d;
      locked_q <= locked_d;
      tout_q   <= tout_d;
      settle_q <= settle_d;
      wdog_q   <= wdog_d;
`ifdef SYNC_DRIFT_MON_EN
      drift_q  <= drift_d;
      perr_p1  <= perr_d;
      last_q   <= last_d;
`endif
    end
  end

  assign ECAT_SYNC_TIME = ecat_q;
  assign SET            = set_q;
  assign LOCKED         = locked_q;
  assign TIMEOUT_ERR    = tout_q;

endmodule

// File: tb/tb_sync_set_ctrl.sv
// Directed scoreboard bench for sync_set_ctrl; drift expectations follow SYNC_DRIFT_MON_EN.
module tb_sync_set_ctrl;

  localparam int unsigned TO  = 200;
  localparam int          GAP = 50;
  localparam logic [63:0] P   = 64'd81920;
`ifdef SYNC_DRIFT_MON_EN
  localparam bit DM = 1'b1;
`else
  localparam bit DM = 1'b0;
`endif

  logic        CLK = 1'b0, RST_N = 1'b0, REQ_VALID = 1'b0, CLEAR_ERR = 1'b0, SYNC = 1'b0;
  logic [63:0] REQ_TIME = '0, SYS_TIME = '0;
  logic        REQ_READY, SET, LOCKED, TIMEOUT_ERR, DRIFT_ERR;
  logic [63:0] ECAT_SYNC_TIME;
  logic [31:0] PERIOD_ERR;
  int          tests = 0, fails = 0;
  logic [63:0] st = 64'd5000;

  typedef enum int {O_SET, O_LOCKED, O_TOUT, O_DRIFT, O_PERR, O_READY, O_ECAT} osel_t;
  typedef struct {
    string       tag;
    osel_t       sel;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  sync_set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_TIME(REQ_TIME),
    .REQ_READY(REQ_READY), .CLEAR_ERR(CLEAR_ERR), .SYNC(SYNC), .SYS_TIME(SYS_TIME),
    .ECAT_SYNC_TIME(ECAT_SYNC_TIME), .SET(SET), .LOCKED(LOCKED),
    .TIMEOUT_ERR(TIMEOUT_ERR), .DRIFT_ERR(DRIFT_ERR), .PERIOD_ERR(PERIOD_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] observe(input osel_t s);
    case (s)
      O_SET:    return {63'b0, SET};
      O_LOCKED: return {63'b0, LOCKED};
      O_TOUT:   return {63'b0, TIMEOUT_ERR};
      O_DRIFT:  return {63'b0, DRIFT_ERR};
      O_PERR:   return {32'b0, PERIOD_ERR};
      O_READY:  return {63'b0, REQ_READY};
      default:  return ECAT_SYNC_TIME;
    endcase
  endfunction

  task automatic push(input string tag, input osel_t s, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_perr(input string tag, input logic [31:0] v);
    push(tag, O_PERR, DM ? {32'b0, v} : 64'd0);
  endtask

  task automatic check_sb();
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] o;
      e = sb.pop_front();
      o = observe(e.sel);
      tests++;
      assert (o === e.val)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    check_sb();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic sync_at(input logic [63:0] t);
    SYNC = 1'b1;
    SYS_TIME = t;
    cycle();
    SYNC = 1'b0;
  endtask

  task automatic good_sync(input string tag, input bit lock_exp);
    idle(GAP);
    st = st + P;
    push(tag, O_LOCKED, 64'(lock_exp));
    push_perr({tag, "_perr"}, 32'd0);
    sync_at(st);
  endtask

  task automatic relock(input string tag);
    good_sync({tag, "_1"}, !DM);
    good_sync({tag, "_2"}, 1'b1);
  endtask

  initial begin
    // Reset values
    push("rst_ready", O_READY, 64'd1);
    push("rst_set", O_SET, 64'd0);
    push("rst_locked", O_LOCKED, 64'd0);
    push("rst_tout", O_TOUT, 64'd0);
    push("rst_drift", O_DRIFT, 64'd0);
    push("rst_perr", O_PERR, 64'd0);
    push("rst_ecat", O_ECAT, 64'd0);
    cycle();
    cycle();
    RST_N = 1'b1;
    push("post_rst_ready", O_READY, 64'd1);
    cycle();
    idle(TO + 20);
    push("idle_no_timeout", O_TOUT, 64'd0);
    cycle();

    // Basic load and lock
    REQ_VALID = 1'b1;
    REQ_TIME = 64'd1_000_000;
    push("acc_ecat", O_ECAT, 64'd1_000_000);
    push("acc_ready", O_READY, 64'd0);
    cycle();
    REQ_VALID = 1'b0;
    idle(GAP);
    st = st + P;
    push("arm_set", O_SET, 64'd1);
    push("arm_locked", O_LOCKED, 64'd0);
    sync_at(st);
    push("set_one_cycle", O_SET, 64'd0);
    cycle();
    idle(GAP);
    st = st + P;
    push("load_locked", O_LOCKED, 64'd0);
    push("load_ready", O_READY, 64'd0);
    sync_at(st);
    good_sync("settle1", 1'b0);
    good_sync("settle2_lock", 1'b1);
    push("lock_ready", O_READY, 64'd1);
    push("lock_set", O_SET, 64'd0);
    cycle();

    // Drift of +80
    idle(GAP);
    st = st + 64'd82000;
    push_perr("drift80_perr", 32'd80);
    push("drift80_flag", O_DRIFT, 64'(DM));
    push("drift80_locked", O_LOCKED, 64'(!DM));
    push("drift80_ready", O_READY, 64'(!DM));
    sync_at(st);
    relock("relock_a");
    CLEAR_ERR = 1'b1;
    push("clear_a_drift", O_DRIFT, 64'd0);
    cycle();
    CLEAR_ERR = 1'b0;

    // Clear coincident with a new violation
    idle(GAP);
    st = st + P - 64'd100;
    CLEAR_ERR = 1'b1;
    push("clr_vs_drift", O_DRIFT, 64'(DM));
    push_perr("clr_vs_perr", 32'hFFFF_FF9C);
    push("clr_vs_locked", O_LOCKED, 64'(!DM));
    sync_at(st);
    CLEAR_ERR = 1'b0;
    relock("relock_b");
    CLEAR_ERR = 1'b1;
    push("clear_b_drift", O_DRIFT, 64'd0);
    push("clear_b_tout", O_TOUT, 64'd0);
    cycle();
    CLEAR_ERR = 1'b0;

    // Tolerance edges
    idle(GAP);
    st = st + P + 64'd64;
    push("tol64_locked", O_LOCKED, 64'd1);
    push("tol64_drift", O_DRIFT, 64'd0);
    push_perr("tol64_perr", 32'd64);
    sync_at(st);
    idle(GAP);
    st = st + P - 64'd65;
    push("tol65_locked", O_LOCKED, 64'(!DM));
    push("tol65_drift", O_DRIFT, 64'(DM));
    push_perr("tol65_perr", 32'hFFFF_FFBF);
    sync_at(st);
    relock("relock_c");

    // Saturation both ways
    idle(GAP);
    st = st + P + 64'h100_0000_0000;
    push_perr("sat_pos", 32'h7FFF_FFFF);
    sync_at(st);
    relock("relock_d");
    idle(GAP);
    st = st + P - 64'h100_0000_0000;
    push_perr("sat_neg", 32'h8000_0001);
    sync_at(st);
    relock("relock_e");

    // SYNC on the expiry cycle is on time
    idle(TO - 1);
    st = st + P;
    push("edge_sync_tout", O_TOUT, 64'd0);
    push("edge_sync_locked", O_LOCKED, 64'd1);
    sync_at(st);

    // Request coincident with SYNC while locked
    idle(GAP);
    st = st + P;
    REQ_VALID = 1'b1;
    REQ_TIME = 64'd2_000_000;
    push("relq_ecat", O_ECAT, 64'd2_000_000);
    push("relq_ready", O_READY, 64'd0);
    push("relq_locked", O_LOCKED, 64'd0);
    push("relq_set", O_SET, 64'd0);
    sync_at(st);
    REQ_VALID = 1'b0;
    push("relq_no_set", O_SET, 64'd0);
    cycle();
    idle(GAP);
    st = st + P;
    push("relq_arm_set", O_SET, 64'd1);
    sync_at(st);
    idle(GAP);
    st = st + P;
    push("relq_load_locked", O_LOCKED, 64'd0);
    sync_at(st);
    good_sync("relq_settle1", 1'b0);
    good_sync("relq_settle2", 1'b1);
    push("relq_ecat_held", O_ECAT, 64'd2_000_000);
    cycle();

    // Timeout exactly TO cycles after the last SYNC
    idle(TO - 3);
    push("pre_tout", O_TOUT, 64'd0);
    push("pre_tout_locked", O_LOCKED, 64'd1);
    cycle();
    push("tout_flag", O_TOUT, 64'd1);
    push("tout_locked", O_LOCKED, 64'd0);
    push("tout_ready", O_READY, 64'd1);
    cycle();
    idle(TO + 20);
    push("err_sticky", O_TOUT, 64'd1);
    sync_at(st + P);
    push("err_no_set", O_SET, 64'd0);
    cycle();
    CLEAR_ERR = 1'b1;
    push("clear_tout", O_TOUT, 64'd0);
    cycle();
    CLEAR_ERR = 1'b0;

    // Leave ERROR by request, then reset in ARM with SYNC
    REQ_VALID = 1'b1;
    REQ_TIME = 64'd3_000_000;
    push("err_acc_ecat", O_ECAT, 64'd3_000_000);
    push("err_acc_ready", O_READY, 64'd0);
    cycle();
    REQ_VALID = 1'b0;
    idle(GAP);
    RST_N = 1'b0;
    push("rst_arm_set", O_SET, 64'd0);
    push("rst_arm_ecat", O_ECAT, 64'd0);
    sync_at(st);
    RST_N = 1'b1;
    push("rst_arm_after_set", O_SET, 64'd0);
    push("rst_arm_after_ready", O_READY, 64'd1);
    cycle();

    // Reset for one cycle while in LOAD
    REQ_VALID = 1'b1;
    REQ_TIME = 64'd4_000_000;
    cycle();
    REQ_VALID = 1'b0;
    idle(GAP);
    push("l_arm_set", O_SET, 64'd1);
    sync_at(st);
    idle(GAP);
    RST_N = 1'b0;
    push("l_rst_set", O_SET, 64'd0);
    push("l_rst_locked", O_LOCKED, 64'd0);
    push("l_rst_ecat", O_ECAT, 64'd0);
    push("l_rst_perr", O_PERR, 64'd0);
    push("l_rst_tout", O_TOUT, 64'd0);
    push("l_rst_drift", O_DRIFT, 64'd0);
    push("l_rst_ready", O_READY, 64'd1);
    sync_at(st + P);
    RST_N = 1'b1;
    push("l_post_set", O_SET, 64'd0);
    push("l_post_ready", O_READY, 64'd1);
    cycle();
    sync_at(st + 2 * P);
    push("idle_sync_no_set", O_SET, 64'd0);
    push("idle_sync_ready", O_READY, 64'd1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
